// File: rtl/audio_playback_scheduler_if.sv
// Memory read port and PWM serializer port of the audio playback scheduler.
// master = scheduler side, slave = memory/serializer side.
interface audio_playback_scheduler_if #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WORD_LENGTH = 16
);
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic                   mem_rd_o;
  logic                   mem_valid_i;
  logic [WORD_LENGTH-1:0] mem_data_i;
  logic [WORD_LENGTH-1:0] word_o;
  logic                   clip_sel_o;
  logic                   ser_enable_o;
  logic                   ser_done_i;

  modport master (
    output mem_addr_o, mem_rd_o, word_o, clip_sel_o, ser_enable_o,
    input  mem_valid_i, mem_data_i, ser_done_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_o, word_o, clip_sel_o, ser_enable_o,
    output mem_valid_i, mem_data_i, ser_done_i
  );
endinterface

// File: rtl/audio_playback_scheduler.sv
// Round-robin scheduler feeding two stored audio clips word by word to a PWM serializer.
// Define UNDERRUN_COUNT_EN to add the saturating underrun counter output underrun_cnt_o.
module audio_playback_scheduler #(
  parameter int unsigned WORD_LENGTH        = 16,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000,
  parameter int unsigned ADDR_WIDTH         = 12
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [1:0]            play_req_i,
  input  logic                  stop_i,
  input  logic [ADDR_WIDTH-1:0] clip_len0_i,
  input  logic [ADDR_WIDTH-1:0] clip_len1_i,
  audio_playback_scheduler_if.master bus_io,
  output logic                  busy_o,
  output logic [1:0]            clip_done_o
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [7:0]            underrun_cnt_o
`endif
);

  localparam int unsigned TickDiv = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
  localparam int unsigned CntW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  if (TickDiv < WORD_LENGTH + 4) begin : g_tick_div_check
    $error("TICK_DIV must be at least WORD_LENGTH+4");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StWaitData, StWaitTick, StShift} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        tick_cnt_q;
  logic [ADDR_WIDTH-1:0]  index_q, len_q, idx_next, grant_len;
  logic [WORD_LENGTH-1:0] word_q;
  logic                   clip_q, last_served_q, ser_en_q;
  logic [1:0]             done_q;
  logic                   tick, req_any, grant_clip, grant_zero, last_word;

  assign tick       = (tick_cnt_q == CntW'(TickDiv - 1));
  assign req_any    = |play_req_i;
  assign grant_len  = grant_clip ? clip_len1_i : clip_len0_i;
  assign grant_zero = (grant_len == '0);
  assign idx_next   = index_q + ADDR_WIDTH'(1);
  assign last_word  = (idx_next == len_q);

  // On contention, serve the clip that did not finish (or stop) last.
  always_comb begin
    grant_clip = play_req_i[1];
    if (&play_req_i) grant_clip = ~last_served_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req_any && !grant_zero) state_d = StFetch;
      StFetch:    state_d = StWaitData;
      StWaitData: if (bus_io.mem_valid_i) state_d = StWaitTick;
      StWaitTick: if (tick) state_d = StShift;
      StShift:    if (bus_io.ser_done_i) state_d = last_word ? StIdle : StFetch;
      default:    state_d = StIdle;
    endcase
    if (stop_i && (state_q != StIdle)) state_d = StIdle;
  end

  always_comb begin
    bus_io.mem_rd_o = (state_q == StFetch);
    busy_o          = (state_q != StIdle);
  end

  assign bus_io.mem_addr_o   = index_q;
  assign bus_io.word_o       = word_q;
  assign bus_io.clip_sel_o   = clip_q;
  assign bus_io.ser_enable_o = ser_en_q;
  assign clip_done_o         = done_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tick_cnt_q    <= '0;
      index_q       <= '0;
      len_q         <= '0;
      word_q        <= '0;
      clip_q        <= 1'b0;
      last_served_q <= 1'b1;
      ser_en_q      <= 1'b0;
      done_q        <= '0;
    end else begin
      done_q <= '0;
      if (state_q == StIdle || tick) tick_cnt_q <= '0;
      else                           tick_cnt_q <= tick_cnt_q + CntW'(1);

      if (state_q == StIdle) begin
        if (req_any) begin
          clip_q  <= grant_clip;
          len_q   <= grant_len;
          index_q <= '0;
          if (grant_zero) begin
            done_q        <= 2'b01 << grant_clip;
            last_served_q <= grant_clip;
          end
        end
      end else if (stop_i) begin
        ser_en_q      <= 1'b0;
        last_served_q <= clip_q;
      end else begin
        if (state_q == StWaitData && bus_io.mem_valid_i) word_q <= bus_io.mem_data_i;
        if (state_q == StWaitTick && tick) ser_en_q <= 1'b1;
        // Dropping enable between words gives the serializer a fresh rising edge.
        if (state_q == StShift && bus_io.ser_done_i) begin
          ser_en_q <= 1'b0;
          if (last_word) begin
            done_q        <= 2'b01 << clip_q;
            last_served_q <= clip_q;
          end else begin
            index_q <= idx_next;
          end
        end
      end
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      underrun_q <= '0;
    end else if (state_q == StIdle && req_any) begin
      underrun_q <= '0;
    end else if (tick && (state_q == StFetch || state_q == StWaitData) &&
                 (underrun_q != 8'hFF)) begin
      underrun_q <= underrun_q + 8'd1;
    end
  end

  assign underrun_cnt_o = underrun_q;
`endif

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Self-checking bench for audio_playback_scheduler: vector table of clip plays with a word
// scoreboard, plus hand-written stop, async-reset and (optionally) underrun sequences.
module tb_audio_playback_scheduler;

  localparam int unsigned WordLength = 16;
  localparam int unsigned AddrWidth  = 12;
  localparam int          TickDiv    = 100;

  typedef struct {
    logic [1:0] req;
    int         len0;
    int         len1;
    int         lat;
    logic       clip;
    int         gap;
    bit         hold;
  } vec_t;

  typedef struct {
    logic        clip;
    logic [15:0] data;
    int          gap;
    bit          first;
  } exp_t;

  logic                 clock_i, reset_i, stop_i, busy_o;
  logic [1:0]           play_req_i, clip_done_o;
  logic [AddrWidth-1:0] clip_len0_i, clip_len1_i;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0]           underrun_cnt_o;
`endif

  audio_playback_scheduler_if #(.ADDR_WIDTH(AddrWidth), .WORD_LENGTH(WordLength)) bus ();

  audio_playback_scheduler #(
    .WORD_LENGTH(WordLength),
    .SYSTEM_FREQUENCY(100000000),
    .SAMPLING_FREQUENCY(1000000),
    .ADDR_WIDTH(AddrWidth)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .play_req_i(play_req_i),
    .stop_i(stop_i),
    .clip_len0_i(clip_len0_i),
    .clip_len1_i(clip_len1_i),
    .bus_io(bus),
    .busy_o(busy_o),
    .clip_done_o(clip_done_o)
`ifdef UNDERRUN_COUNT_EN
    ,
    .underrun_cnt_o(underrun_cnt_o)
`endif
  );

  int   cyc, checks, errors, rd_cnt, ser_cnt, mem_cnt, mem_lat, mem_addr_v;
  int   grant_cyc, last_rise, ser_words, stop_arm;
  bit   pend, mem_clip, ser_en_prev, busy_prev, busy_seen, stop_fired;
  logic [1:0] done_now;
  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[6];

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance to the falling edge, run the memory/serializer models and monitors.
  task automatic step();
    @(negedge clock_i);
    cyc++;
    if (reset_i) begin
      pend    = 1'b0;
      ser_cnt = 0;
    end
    if (busy_o && !busy_prev) grant_cyc = cyc;
    busy_prev = busy_o;
    busy_seen = busy_seen | busy_o;

    bus.ser_done_i = 1'b0;
    stop_i         = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) begin
        bus.ser_done_i = 1'b1;
        ser_words++;
        check("word_stable", 32'(bus.word_o), 32'(cur.data));
        if (stop_arm != 0 && ser_words == stop_arm) begin
          stop_i     = 1'b1;
          stop_fired = 1'b1;
          stop_arm   = 0;
        end
      end
    end
    if (bus.ser_enable_o && !ser_en_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h with nothing expected", bus.word_o);
      end else begin
        cur = exp_q.pop_front();
        check("word", 32'(bus.word_o), 32'(cur.data));
        check("clip_sel", 32'(bus.clip_sel_o), 32'(cur.clip));
        if (cur.gap > 0)
          check("word_gap", cyc - (cur.first ? grant_cyc : last_rise), cur.gap);
      end
      last_rise = cyc;
      ser_cnt   = WordLength;
    end
    ser_en_prev = bus.ser_enable_o;

    bus.mem_valid_i = 1'b0;
    if (pend) begin
      if (mem_cnt <= 1) begin
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = (mem_clip ? 16'hB000 : 16'hA000) + 16'(mem_addr_v + 1);
        pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (bus.mem_rd_o) begin
      rd_cnt++;
      pend       = 1'b1;
      mem_cnt    = mem_lat;
      mem_addr_v = int'(bus.mem_addr_o);
      mem_clip   = bus.clip_sel_o;
    end
    done_now = clip_done_o;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    play_req_i  = v.req;
    clip_len0_i = AddrWidth'(v.len0);
    clip_len1_i = AddrWidth'(v.len1);
    mem_lat     = v.lat;
    n = v.clip ? v.len1 : v.len0;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{clip: v.clip, data: (v.clip ? 16'hB000 : 16'hA000) + 16'(i + 1),
                        gap: v.gap, first: (i == 0)});
    rd_cnt    = 0;
    busy_seen = 1'b0;
    done_now  = '0;
    for (int k = 0; k < 5000 && done_now == 2'b00; k++) step();
    check({tag, "_clip_done"}, 32'(done_now), 32'(2'b01 << v.clip));
    check({tag, "_mem_reads"}, rd_cnt, n);
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(n > 0));
    if (!v.hold) begin
      play_req_i = 2'b00;
      step();
      check({tag, "_idle_busy"}, 32'(busy_o), 0);
      check({tag, "_done_one_cycle"}, 32'(clip_done_o), 0);
    end
  endtask

  initial begin
    vecs[0] = '{req: 2'b01, len0: 3, len1: 0, lat: 2, clip: 1'b0, gap: TickDiv, hold: 1'b0};
    vecs[1] = '{req: 2'b10, len0: 0, len1: 0, lat: 2, clip: 1'b1, gap: TickDiv, hold: 1'b0};
    vecs[2] = '{req: 2'b11, len0: 2, len1: 2, lat: 2, clip: 1'b0, gap: TickDiv, hold: 1'b1};
    vecs[3] = '{req: 2'b11, len0: 2, len1: 2, lat: 2, clip: 1'b1, gap: TickDiv, hold: 1'b1};
    vecs[4] = '{req: 2'b11, len0: 2, len1: 2, lat: 2, clip: 1'b0, gap: TickDiv, hold: 1'b1};
    vecs[5] = '{req: 2'b11, len0: 2, len1: 2, lat: 2, clip: 1'b1, gap: TickDiv, hold: 1'b0};

    cyc = 0; checks = 0; errors = 0; rd_cnt = 0; ser_cnt = 0; mem_cnt = 0; mem_lat = 2;
    mem_addr_v = 0; grant_cyc = 0; last_rise = 0; ser_words = 0; stop_arm = 0;
    pend = 1'b0; mem_clip = 1'b0; ser_en_prev = 1'b0; busy_prev = 1'b0; busy_seen = 1'b0;
    stop_fired = 1'b0; done_now = '0;
    cur = '{clip: 1'b0, data: 16'h0, gap: 0, first: 1'b0};
    reset_i = 1'b1; stop_i = 1'b0; play_req_i = 2'b00; clip_len0_i = '0; clip_len1_i = '0;
    bus.mem_valid_i = 1'b0; bus.mem_data_i = '0; bus.ser_done_i = 1'b0;

    #3;
    check("reset_busy", 32'(busy_o), 0);
    check("reset_ser_enable", 32'(bus.ser_enable_o), 0);
    check("reset_mem_rd", 32'(bus.mem_rd_o), 0);
    check("reset_word", 32'(bus.word_o), 0);
    check("reset_clip_done", 32'(clip_done_o), 0);
    repeat (3) step();
    reset_i = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Slow memory: the first tick of each word is missed, so words land 200 cycles apart.
    run_vec('{req: 2'b01, len0: 2, len1: 0, lat: 150, clip: 1'b0, gap: 2 * TickDiv,
              hold: 1'b0}, "underrun");
`ifdef UNDERRUN_COUNT_EN
    check("underrun_cnt", 32'(underrun_cnt_o), 2);
`endif

    // stop_i coincides with ser_done_i of word 2 of a 5-word clip.
    mem_lat = 2; ser_words = 0; stop_arm = 2; stop_fired = 1'b0;
    play_req_i = 2'b01; clip_len0_i = AddrWidth'(5);
    for (int i = 0; i < 2; i++)
      exp_q.push_back('{clip: 1'b0, data: 16'hA000 + 16'(i + 1), gap: TickDiv, first: (i == 0)});
    for (int k = 0; k < 100 && !busy_o; k++) step();
    play_req_i = 2'b00;
    for (int k = 0; k < 2000 && !stop_fired; k++) step();
    check("stop_fired", 32'(stop_fired), 1);
    step();
    check("stop_ser_enable", 32'(bus.ser_enable_o), 0);
    check("stop_busy", 32'(busy_o), 0);
    rd_cnt = 0;
    done_now = '0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (done_now != 2'b00) check("stop_no_clip_done", 32'(done_now), 0);
    end
    check("stop_no_fetch", rd_cnt, 0);
    check("stop_stays_idle", 32'(busy_o), 0);

    // Asynchronous reset in the middle of SHIFT, then contention must favour clip 0.
    play_req_i = 2'b01; clip_len0_i = AddrWidth'(4);
    exp_q.push_back('{clip: 1'b0, data: 16'hA001, gap: TickDiv, first: 1'b1});
    for (int k = 0; k < 500 && !bus.ser_enable_o; k++) step();
    check("pre_reset_shift", 32'(bus.ser_enable_o), 1);
    play_req_i = 2'b00;
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_ser_enable", 32'(bus.ser_enable_o), 0);
    check("async_reset_busy", 32'(busy_o), 0);
    check("async_reset_word", 32'(bus.word_o), 0);
    check("async_reset_mem_rd", 32'(bus.mem_rd_o), 0);
    check("async_reset_clip_done", 32'(clip_done_o), 0);
`ifdef UNDERRUN_COUNT_EN
    check("async_reset_underrun", 32'(underrun_cnt_o), 0);
`endif
    repeat (3) step();
    reset_i = 1'b0;
    run_vec('{req: 2'b11, len0: 1, len1: 1, lat: 2, clip: 1'b0, gap: TickDiv, hold: 1'b0},
            "post_reset");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
